imm_ext_unit: RTL and testbench
===============================

# imm_ext_unit

Parametrised, pipelined immediate extender for the processor decode stage. It accepts raw immediate fields with a valid/ready handshake and applies one of four extension modes. A prefix mode supplies the upper bits of the next immediate. The result is delivered through one registered output stage with backpressure.

## Interface
Parameters:
- IN_W, 12, raw immediate width; at least 2.
- OUT_W, 16, result width; must be greater than IN_W.
- SHAMT, 1, left shift used by mode SHL; range 0..OUT_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  IN_W  raw immediate field.
- mode  input  2  00 SEXT, 01 ZEXT, 10 SHL, 11 PFX.
- in_valid  input  1  in/mode are valid this cycle.
- in_ready  output  1  unit can accept this cycle.
- flush  input  1  discard any held prefix.
- out  output  OUT_W  extended immediate.
- out_valid  output  1  out holds a result.
- out_ready  input  1  consumer takes out this cycle.
- err  output  1  one-cycle pulse: PFX accepted while a prefix was already held.

One clock; reset is synchronous and active-high.

## Operation
- Accept occurs when in_valid && in_ready.
- Base extension of a non-PFX accept:
  - SEXT replicates in[IN_W-1] into bits OUT_W-1..IN_W.
  - ZEXT fills those bits with 0.
  - SHL takes the SEXT value shifted left by SHAMT, truncated to OUT_W, with zeros shifted in.
- Prefix FSM has two states, IDLE and HELD.
  - IDLE + PFX accept: latch in[OUT_W-IN_W-1:0] into pfx (P = OUT_W-IN_W bits); go to HELD; no output is produced.
  - HELD + non-PFX accept: bits OUT_W-1..IN_W of the pre-shift value become pfx instead of the extension bits. For SHL, the shift is applied after the substitution. Go to IDLE.
  - HELD + PFX accept: pfx is overwritten, err pulses on the next cycle, and the state stays HELD.
- flush forces IDLE.
  - If flush coincides with a non-PFX accept, that accept is extended without the prefix.
  - If flush coincides with a PFX accept, the new prefix is latched and the state is HELD.
  - flush does not affect the output register.
- Output register:
  - in_ready = !out_valid || out_ready.
  - A non-PFX accept loads out and sets out_valid.
  - out_valid clears when out_ready is high and no new result loads in the same cycle.
  - out and out_valid hold stable while out_valid && !out_ready.

## Timing
- Latency from accept to out_valid: 1 cycle.
- Throughput: 1 result per cycle when out_ready is held high.
- PFX accepts consume one input cycle and produce no result.
- Reset values: out = 0, out_valid = 0, err = 0, FSM = IDLE, pfx = 0. in_ready is 1 the cycle after reset.
- A reset asserted while HELD discards the prefix. The first accept after reset extends normally.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in to out.

## Configuration
- IMM_EXT_PREFIX_EN defined: the prefix FSM, the pfx register and err are present as described above.
- IMM_EXT_PREFIX_EN undefined:
  - mode 11 is treated as SEXT and produces a result.
  - flush is ignored.
  - err is tied to 0.
  - No prefix state is synthesised.

## Structure
- The shared package holds:
  - the typedef for the 2-bit mode with constants MODE_SEXT, MODE_ZEXT, MODE_SHL, MODE_PFX;
  - the state typedef with constants ST_IDLE and ST_HELD.
- One sub-module, imm_ext_comb, does the pure combinational extension. Its inputs are in, mode, pfx and use_pfx; its output is the OUT_W value.
- The top level owns the FSM, the pfx register and the output register.

## Test plan
All scenarios use default parameters (IN_W=12, OUT_W=16, SHAMT=1).
- Mode sweep, out_ready held 1: SEXT 0x880 -> 0xF880; ZEXT 0x880 -> 0x0880; SHL 0x801 -> 0xF002. Each result appears 1 cycle after its accept.
- Prefix: PFX 0x00A then SEXT 0x123 -> 0xA123. Only one out_valid pulse occurs, and the next SEXT 0x123 -> 0x0123.
- Double prefix: PFX 0x005, then PFX 0x00C, then ZEXT 0x0FF -> 0xC0FF. err pulses once, the cycle after the second PFX.
- Backpressure: with out_ready = 0, SEXT 0x7FF is accepted -> out = 0x07FF held and in_ready = 0. A second input is stalled until out_ready = 1, then delivered as the next result with no drop or duplicate.
- flush and reset: PFX 0x003 then flush together with SEXT 0xFFF -> 0xFFFF. Also, PFX 0x003 then reset, then ZEXT 0x001 -> 0x0001, with all outputs 0 during reset.
- Build without IMM_EXT_PREFIX_EN: mode 11 with in = 0x800 -> 0xF800, and err stays 0.

Source files
------------

// File: rtl/imm_ext_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_unit_pkg
//  Description : Shared mode and prefix-state encodings for the immediate
//                extender (imm_ext_comb, imm_ext_unit).
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_unit_pkg;

    // Extension mode carried alongside each raw immediate
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_SEXT = 2'b00;
    localparam mode_t MODE_ZEXT = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_PFX  = 2'b11;

    // Prefix tracker: IDLE (no prefix held) or HELD (pfx waiting for a user)
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_HELD = 1'b1;

endpackage : imm_ext_unit_pkg
`default_nettype wire

// File: rtl/imm_ext_comb.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_comb
//  Description : Pure combinational immediate extension. Builds the pre-shift
//                value {upper, in} where upper is the sign/zero fill or a held
//                prefix, then applies the SHL shift when selected.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_comb
    import imm_ext_unit_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int SHAMT = 1
) (
    input  logic [IN_W-1:0]        in,
    input  mode_t                  mode,
    input  logic [OUT_W-IN_W-1:0]  pfx,
    input  logic                   use_pfx,
    output logic [OUT_W-1:0]       out
);

    localparam int c_P_W = OUT_W - IN_W;

    logic [c_P_W-1:0] w_upper;
    logic [OUT_W-1:0] w_pre;

    // Select the upper fill bits, form the pre-shift value and apply SHL
    always_comb begin
        w_upper = {c_P_W{in[IN_W-1]}};
        if (use_pfx) begin
            w_upper = pfx;
        end else if (mode == MODE_ZEXT) begin
            w_upper = '0;
        end
        w_pre = {w_upper, in};
        out   = w_pre;
        if (mode == MODE_SHL) begin
            out = w_pre << SHAMT;
        end
    end

endmodule : imm_ext_comb
`default_nettype wire

// File: rtl/imm_ext_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_unit
//  Description : Pipelined immediate extender with valid/ready input, one
//                registered output stage with backpressure, and an optional
//                prefix mechanism supplying the upper bits of the next result.
//                Optional feature macro: IMM_EXT_PREFIX_EN (prefix FSM, pfx
//                register and err pulse; when undefined mode 11 acts as SEXT).
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_unit
    import imm_ext_unit_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int SHAMT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   in,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    localparam int c_P_W = OUT_W - IN_W;

    logic             w_accept;
    logic             w_load;
    logic             w_use_pfx;
    logic [c_P_W-1:0] w_pfx;
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_out;
    logic             r_out_valid;

    // Nothing is accepted while reset is asserted, so in_ready reads 0 then
    assign in_ready = !reset && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef IMM_EXT_PREFIX_EN
    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_P_W-1:0] r_pfx;
    logic [c_P_W-1:0] w_pfx_in;
    logic             r_err;
    logic             w_is_pfx;
    logic             w_held_eff;

    // Prefix field is the low P bits of in, zero-padded if P exceeds IN_W
    if (c_P_W <= IN_W) begin : g_pfx_narrow
        assign w_pfx_in = in[c_P_W-1:0];
    end else begin : g_pfx_wide
        assign w_pfx_in = {{(c_P_W-IN_W){1'b0}}, in};
    end

    // A flush in the same cycle drops the held prefix before it can be used
    assign w_is_pfx   = (mode == MODE_PFX);
    assign w_held_eff = (r_state == ST_HELD) && !flush;
    assign w_use_pfx  = w_held_eff;
    assign w_pfx      = r_pfx;
    assign w_load     = w_accept && !w_is_pfx;
    assign err        = r_err;

    // Next prefix state: flush clears, a PFX accept holds, any other accept releases
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
        if (w_accept) begin
            w_state_nxt = w_is_pfx ? ST_HELD : ST_IDLE;
        end
    end

    // Prefix state, prefix register and double-prefix error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pfx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && w_is_pfx && w_held_eff;
            if (w_accept && w_is_pfx) begin
                r_pfx <= w_pfx_in;
            end
        end
    end
`else
    logic w_unused_flush;

    // Without prefix support every accept produces a result and flush is inert
    assign w_unused_flush = flush;
    assign w_use_pfx      = 1'b0;
    assign w_pfx          = '0;
    assign w_load         = w_accept;
    assign err            = 1'b0;
`endif

    imm_ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHAMT (SHAMT)
    ) u_comb (
        .in      (in),
        .mode    (mode_t'(mode)),
        .pfx     (w_pfx),
        .use_pfx (w_use_pfx),
        .out     (w_ext)
    );

    // Output stage: load on a producing accept, drain when the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out       <= w_ext;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule : imm_ext_unit
`default_nettype wire

// File: tb/tb_imm_ext_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_ext_unit
//  Description : Directed self-checking bench for imm_ext_unit with default
//                parameters. Prefix scenarios run when IMM_EXT_PREFIX_EN is
//                defined; otherwise the mode-11-as-SEXT scenario runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_unit;

    logic        clk;
    logic        reset;
    logic [11:0] in;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int passed;
    int total;

    imm_ext_unit #(
        .IN_W  (12),
        .OUT_W (16),
        .SHAMT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input for exactly one clock edge, return 1 time unit after it
    task automatic accept_one(input logic [1:0] m, input logic [11:0] d);
        in       = d;
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out !== 16'h0000) $display("FAIL reset_out: got %h expected %h", out, 16'h0000);
        else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0);
        else passed++;
        total++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b expected %b", err, 1'b0);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected %b", in_ready, 1'b1);
        else passed++;
    endtask

    task automatic test_mode_sweep;
        out_ready = 1'b1;
        accept_one(2'b00, 12'h880);
        total++;
        if (out_valid !== 1'b1 || out !== 16'hF880) $display("FAIL sweep_sext: got %h/%b expected %h/1", out, out_valid, 16'hF880);
        else passed++;
        accept_one(2'b01, 12'h880);
        total++;
        if (out_valid !== 1'b1 || out !== 16'h0880) $display("FAIL sweep_zext: got %h/%b expected %h/1", out, out_valid, 16'h0880);
        else passed++;
        accept_one(2'b10, 12'h801);
        total++;
        if (out_valid !== 1'b1 || out !== 16'hF002) $display("FAIL sweep_shl: got %h/%b expected %h/1", out, out_valid, 16'hF002);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL sweep_drain: got %b expected %b", out_valid, 1'b0);
        else passed++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        accept_one(2'b00, 12'h7FF);
        total++;
        if (out_valid !== 1'b1 || out !== 16'h07FF) $display("FAIL bp_first: got %h/%b expected %h/1", out, out_valid, 16'h07FF);
        else passed++;
        total++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b expected %b", in_ready, 1'b0);
        else passed++;
        in       = 12'h0AA;
        mode     = 2'b01;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out !== 16'h07FF) $display("FAIL bp_hold: got %h/%b expected %h/1", out, out_valid, 16'h07FF);
        else passed++;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_in_ready_high: got %b expected %b", in_ready, 1'b1);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out !== 16'h00AA) $display("FAIL bp_second: got %h/%b expected %h/1", out, out_valid, 16'h00AA);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_no_duplicate: got %b expected %b", out_valid, 1'b0);
        else passed++;
    endtask

`ifdef IMM_EXT_PREFIX_EN
    task automatic test_prefix;
        out_ready = 1'b1;
        accept_one(2'b11, 12'h00A);
        total++;
        if (out_valid !== 1'b0) $display("FAIL pfx_no_output: got %b expected %b", out_valid, 1'b0);
        else passed++;
        accept_one(2'b00, 12'h123);
        total++;
        if (out_valid !== 1'b1 || out !== 16'hA123) $display("FAIL pfx_use: got %h/%b expected %h/1", out, out_valid, 16'hA123);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL pfx_single_pulse: got %b expected %b", out_valid, 1'b0);
        else passed++;
        accept_one(2'b00, 12'h123);
        total++;
        if (out !== 16'h0123) $display("FAIL pfx_consumed: got %h expected %h", out, 16'h0123);
        else passed++;
    endtask

    task automatic test_double_prefix;
        accept_one(2'b11, 12'h005);
        total++;
        if (err !== 1'b0) $display("FAIL dpfx_no_err_first: got %b expected %b", err, 1'b0);
        else passed++;
        accept_one(2'b11, 12'h00C);
        total++;
        if (err !== 1'b1) $display("FAIL dpfx_err_pulse: got %b expected %b", err, 1'b1);
        else passed++;
        accept_one(2'b01, 12'h0FF);
        total++;
        if (err !== 1'b0) $display("FAIL dpfx_err_clear: got %b expected %b", err, 1'b0);
        else passed++;
        total++;
        if (out_valid !== 1'b1 || out !== 16'hC0FF) $display("FAIL dpfx_result: got %h/%b expected %h/1", out, out_valid, 16'hC0FF);
        else passed++;
    endtask

    task automatic test_flush;
        accept_one(2'b11, 12'h003);
        flush = 1'b1;
        accept_one(2'b00, 12'hFFF);
        flush = 1'b0;
        total++;
        if (out !== 16'hFFFF) $display("FAIL flush_result: got %h expected %h", out, 16'hFFFF);
        else passed++;
        accept_one(2'b01, 12'h123);
        total++;
        if (out !== 16'h0123) $display("FAIL flush_idle_after: got %h expected %h", out, 16'h0123);
        else passed++;
    endtask

    task automatic test_reset_held;
        accept_one(2'b11, 12'h003);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out !== 16'h0000 || out_valid !== 1'b0 || err !== 1'b0) $display("FAIL rst_held_outputs: got %h/%b/%b expected 0000/0/0", out, out_valid, err);
        else passed++;
        reset = 1'b0;
        accept_one(2'b01, 12'h001);
        total++;
        if (out_valid !== 1'b1 || out !== 16'h0001) $display("FAIL rst_held_after: got %h/%b expected %h/1", out, out_valid, 16'h0001);
        else passed++;
    endtask
`else
    task automatic test_no_prefix;
        out_ready = 1'b1;
        accept_one(2'b11, 12'h800);
        total++;
        if (out_valid !== 1'b1 || out !== 16'hF800) $display("FAIL nopfx_mode11: got %h/%b expected %h/1", out, out_valid, 16'hF800);
        else passed++;
        total++;
        if (err !== 1'b0) $display("FAIL nopfx_err: got %b expected %b", err, 1'b0);
        else passed++;
        accept_one(2'b01, 12'h800);
        total++;
        if (out !== 16'h0800) $display("FAIL nopfx_next_zext: got %h expected %h", out, 16'h0800);
        else passed++;
        total++;
        if (err !== 1'b0) $display("FAIL nopfx_err_after: got %b expected %b", err, 1'b0);
        else passed++;
    endtask
`endif

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        in        = '0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_mode_sweep();
        test_backpressure();
`ifdef IMM_EXT_PREFIX_EN
        test_prefix();
        test_double_prefix();
        test_flush();
        test_reset_held();
`else
        test_no_prefix();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_imm_ext_unit
`default_nettype wire
